// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and fetch FSM state type for the fetch slice
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef enum logic {RUN, DRAIN} fetch_state_e;
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {inst, pc} buffer; flush overrides push and pop on the same edge
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [INST_W-1:0]       push_inst,
    input  logic [XLEN-1:0]         push_pc,
    output logic [INST_W-1:0]       head_inst,
    output logic [XLEN-1:0]         head_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && !flush;
        do_pop = pop && !flush && !empty;
        full = count == CW'(DEPTH);
        empty = count == '0;
        head_inst = inst_mem[rd_ptr];
        head_pc = pc_mem[rd_ptr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr] <= push_pc;
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: credit-limited in-order instruction fetch with redirect flush and drain.
// Define IFETCH_PERF_EN to add saturating perf_fetched/perf_stall/perf_flushed counters.
module inst_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_gnt,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instOut,
    output logic [31:0] pcOut
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_flushed
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e state, state_next;
    logic started;
    logic [XLEN-1:0] fetch_pc, resp_pc, head_pc;
    logic [INST_W-1:0] head_inst;
    logic [CW-1:0] outstanding, drop, out_next, drop_next, fifo_count;
    logic rsp, issue, push, pop, fifo_full, fifo_empty;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .push_inst(imem_rdata),
        .push_pc(resp_pc),
        .head_inst(head_inst),
        .head_pc(head_pc),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );

    // a response with nothing outstanding is stale traffic from before reset
    always_comb begin
        rsp = imem_rvalid && outstanding != '0;
        issue = imem_req && imem_gnt;
        pop = inst_valid && inst_ready && !redirect_valid;
        push = rsp && drop == '0 && !redirect_valid && (!fifo_full || pop);
        out_next = outstanding + CW'(issue) - CW'(rsp);
        drop_next = redirect_valid ? out_next : drop - CW'(rsp && drop != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else state <= state_next;
    end

    always_comb begin
        state_next = (state == RUN) ? ((redirect_valid && out_next != '0) ? DRAIN : RUN)
                                    : ((drop_next == '0) ? RUN : DRAIN);
    end

    // credit uses registered counts only, so inst_ready never reaches imem_req
    always_comb begin
        imem_req = started && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH) && !redirect_valid;
        imem_addr = fetch_pc;
        inst_valid = !fifo_empty;
        instOut = fifo_empty ? NOP_INST : head_inst;
        pcOut = fifo_empty ? resp_pc : head_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop <= '0;
        end else begin
            started <= 1'b1;
            outstanding <= out_next;
            drop <= drop_next;
            fetch_pc <= redirect_valid ? align_pc(redirect_pc) : issue ? fetch_pc + PC_STEP : fetch_pc;
            resp_pc <= redirect_valid ? align_pc(redirect_pc) : push ? resp_pc + PC_STEP : resp_pc;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [16:0] flush_sum;
    always_comb begin
        flush_sum = {1'b0, perf_flushed} + (redirect_valid ? 17'(fifo_count) : 17'd0)
                  + 17'(rsp && (drop != '0 || redirect_valid));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= (pop && perf_fetched != '1) ? perf_fetched + 32'd1 : perf_fetched;
            perf_stall <= (inst_ready && !inst_valid && perf_stall != '1) ? perf_stall + 32'd1 : perf_stall;
            perf_flushed <= flush_sum[16] ? '1 : flush_sum[15:0];
        end
    end
`endif
endmodule
